pc_fetch_ctrl: RTL
==================

// Module: pc_fetch_ctrl
// PURPOSE
//   Parametrised program-counter and next-PC controller for the RV32I core fetch stage.
//   Holds the architectural PC and selects the next PC from these sources:
//   sequential increment, branch/jump redirect, trap entry and trap return.
//   Handles stall and fetch handshake, and detects misaligned redirect targets.
//   Sits between the fetch stage (instruction memory request) and the execute/CSR logic.
// PARAMETERS
//   XLEN          32             PC / address width in bits
//   RESET_VECTOR  32'h0000_0000  PC value loaded on reset (XLEN bits)
//   TRAP_VECTOR   32'h0000_0100  PC loaded on trap entry (XLEN bits, must be IALIGN-aligned)
//   IALIGN        32             instruction alignment, 32 or 16; INC = IALIGN/8 (4 or 2)
// PORTS
//   clk                 in   1     clock, rising edge
//   rst                 in   1     asynchronous reset, active-low
//   fetch_ready_i       in   1     imem accepts the request at pc_o this cycle
//   stall_i             in   1     pipeline hazard; hold PC
//   redirect_i          in   1     taken branch/jump from execute
//   redirect_target_i   in   XLEN  branch/jump target
//   trap_i              in   1     trap entry request
//   trap_return_i       in   1     mret
//   epc_i               in   XLEN  return address for mret
//   pc_o                out  XLEN  current PC (registered)
//   pc_inc_o            out  XLEN  pc_o + INC (combinational, wraps mod 2^XLEN)
//   fetch_valid_o       out  1     pc_o is a valid fetch request
//   flush_o             out  1     comb.; a redirect/trap/mret is taken this cycle (squash IF/ID)
//   misalign_o          out  1     registered 1-cycle pulse: rejected misaligned redirect
//   misalign_addr_o     out  XLEN  offending target; held until next misalign
// BEHAVIOUR
//   Reset (rst=0, async):
//     pc_o=RESET_VECTOR, state=BOOT, fetch_valid_o=0, misalign_o=0, misalign_addr_o=0.
//     Async assert; deassert is sampled at clk.
//   States:
//     BOOT: one cycle, fetch_valid_o=0; always -> RUN.
//     RUN:  fetch_valid_o=1.
//     HALT: fetch_valid_o=0; only trap_i leaves it (-> RUN).
//   Next-PC priority, evaluated each cycle in RUN (highest first):
//     1 trap_i: pc<=TRAP_VECTOR, flush_o=1. Same in BOOT and HALT, -> RUN.
//     2 trap_return_i: pc<=epc_i with bit0 cleared, flush_o=1.
//     3 redirect_i: tgt = redirect_target_i with bit0 cleared.
//       If IALIGN==32 and tgt[1]==1: pc holds, next cycle misalign_o=1 and misalign_addr_o=tgt,
//       state -> HALT, flush_o=1.
//       Else pc<=tgt, flush_o=1.
//     4 stall_i, or !fetch_ready_i: pc holds.
//     5 otherwise (handshake fetch_valid_o & fetch_ready_i): pc<=pc_o+INC.
//   Flush sources (trap/mret/redirect) override stall_i and ignore fetch_ready_i.
//   BOOT: inputs other than trap_i are ignored.
//   HALT: inputs other than trap_i are ignored; pc_o holds.
//   Arithmetic: XLEN-bit unsigned. 32'hFFFF_FFFC+4 -> 32'h0000_0000; no overflow flag.
//   fetch_valid_o, once high, stays high with pc_o stable until accepted or flushed.
//   Reset mid-operation: immediate return to reset values, regardless of state or pending inputs.
//   Invalid IALIGN (not 16/32): elaboration error via $error in generate.
// TESTING
//   1 Reset then 3 cycles fetch_ready_i=1: pc_o = 0 (BOOT, valid=0), 0, 4, 8.
//   2 stall_i=1 for 2 cycles at pc=8: pc_o stays 8, valid stays 1; release -> 12.
//   3 redirect_i=1, target 32'h0000_0041, with stall_i=1: flush_o=1; next cycle pc_o=32'h40.
//   4 redirect target 32'h0000_0022 (IALIGN=32): misalign_o pulses, misalign_addr_o=32'h22,
//     valid=0 (HALT); then trap_i -> pc_o=32'h100.
//   5 trap_i and redirect_i in same cycle -> pc_o=TRAP_VECTOR.
//     Then trap_return_i, epc_i=32'h84 -> pc_o=32'h84.
//   6 Wrap: RESET_VECTOR=32'hFFFF_FFF8 -> pc sequence FFF8, FFFC, 0000_0000.
//     rst pulsed mid-run -> pc_o=RESET_VECTOR immediately.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Program counter and next-PC selection for the RV32I fetch stage.
// Arbitrates trap entry, trap return, redirects and sequential fetch, and halts on misaligned redirects.
module pc_fetch_ctrl #(
  parameter int                 XLEN         = 32,
  parameter logic [XLEN-1:0]    RESET_VECTOR = '0,
  parameter logic [XLEN-1:0]    TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int                 IALIGN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_ready_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_i,
  input  logic            trap_return_i,
  input  logic [XLEN-1:0] epc_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_inc_o,
  output logic            fetch_valid_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  if (IALIGN != 32 && IALIGN != 16) begin : g_bad_ialign
    $error("pc_fetch_ctrl: IALIGN must be 16 or 32");
  end

  localparam logic [XLEN-1:0] INC      = XLEN'(IALIGN / 8);
  localparam logic [XLEN-1:0] BIT0_CLR = ~XLEN'(1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_misalign, w_misalign_nxt;
  logic [XLEN-1:0] r_misalign_addr, w_misalign_addr_nxt;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_epc;
  logic            w_tgt_misaligned;

  assign w_tgt            = redirect_target_i & BIT0_CLR;
  assign w_epc            = epc_i & BIT0_CLR;
  // With 16-bit instructions every even target is legal.
  assign w_tgt_misaligned = (IALIGN == 32) && w_tgt[1];

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    w_state_nxt         = r_state;
    w_pc_nxt            = r_pc;
    w_misalign_nxt      = 1'b0;
    w_misalign_addr_nxt = r_misalign_addr;
    flush_o             = 1'b0;
    if (trap_i) begin
      w_pc_nxt    = TRAP_VECTOR;
      w_state_nxt = ST_RUN;
      flush_o     = 1'b1;
    end else begin
      unique case (r_state)
        ST_BOOT: w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (trap_return_i) begin
            w_pc_nxt = w_epc;
            flush_o  = 1'b1;
          end else if (redirect_i) begin
            flush_o = 1'b1;
            if (w_tgt_misaligned) begin
              w_misalign_nxt      = 1'b1;
              w_misalign_addr_nxt = w_tgt;
              w_state_nxt         = ST_HALT;
            end else begin
              w_pc_nxt = w_tgt;
            end
          end else if (!stall_i && fetch_ready_i) begin
            w_pc_nxt = r_pc + INC;
          end
        end
        ST_HALT: ;
        default: w_state_nxt = ST_BOOT;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_BOOT;
      r_pc            <= RESET_VECTOR;
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_pc            <= w_pc_nxt;
      r_misalign      <= w_misalign_nxt;
      r_misalign_addr <= w_misalign_addr_nxt;
    end
  end

  assign pc_o            = r_pc;
  assign pc_inc_o        = r_pc + INC;
  assign fetch_valid_o   = (r_state == ST_RUN);
  assign misalign_o      = r_misalign;
  assign misalign_addr_o = r_misalign_addr;

endmodule
